// File: rtl/acc_pkg.sv
// Shared constants for the shift-and-add multiplier: operand/register widths
// and the control FSM state encodings used by the upstream controller.
package acc_pkg;

  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 2 * N + 1;

  // Control FSM state encodings (consumed by the multiplier controller)
  localparam int unsigned ST_W  = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_TEST  = 2'd1;
  localparam logic [ST_W-1:0] ST_ADD   = 2'd2;
  localparam logic [ST_W-1:0] ST_SHIFT = 2'd3;

endpackage : acc_pkg

// File: rtl/acc.sv
// Accumulator register of the shift-and-add multiplier.
// Upper field [WIDTH-1:N] holds the partial product (sum + carry), lower field
// [N-1:0] holds the multiplier bits still to be consumed.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (clears register)
//   load     parallel load of all WIDTH bits from entrada
//   ad       load upper field from entrada[WIDTH-1:N], lower field kept
//   sh       logical right shift by one, MSB zero-filled
//   entrada  data input (operand on load, adder sum on ad)
//   saida    register contents, straight from the flops
module acc
  import acc_pkg::*;
#(
  parameter int unsigned P_N     = N,
  parameter int unsigned P_WIDTH = 2 * P_N + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               sh,
  input  logic               ad,
  input  logic [P_WIDTH-1:0] entrada,
  output logic [P_WIDTH-1:0] saida
);

  logic [P_WIDTH-1:0] r_acc;

  // Prioritised update: rst > load > ad > sh > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (load) begin
      r_acc <= entrada;
    end else if (ad) begin
      r_acc[P_WIDTH-1:P_N] <= entrada[P_WIDTH-1:P_N];
    end else if (sh) begin
      r_acc <= {1'b0, r_acc[P_WIDTH-1:1]};
    end
  end

  assign saida = r_acc;

endmodule : acc

// File: tb/tb_acc.sv
// Directed self-checking bench for the multiplier accumulator register.
module tb_acc;
  import acc_pkg::*;

  logic             clk;
  logic             rst;
  logic             load;
  logic             sh;
  logic             ad;
  logic [WIDTH-1:0] entrada;
  logic [WIDTH-1:0] saida;

  int unsigned n_err;
  int unsigned n_chk;

  acc dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .sh      (sh),
    .ad      (ad),
    .entrada (entrada),
    .saida   (saida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive controls away from the edge, clock once, sample after the edge
  task automatic cyc(input logic r, input logic l, input logic a, input logic s,
                     input logic [WIDTH-1:0] e);
    @(negedge clk);
    rst = r; load = l; ad = a; sh = s; entrada = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_v;
    n_err = 0;
    n_chk = 0;
    rst = 1'b0; load = 1'b0; ad = 1'b0; sh = 1'b0; entrada = '0;

    // Reset wins over load
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 9'b0_1010_1100);
    chk("reset", saida, 9'b0_0000_0000);

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'b0_1010_1100);
    chk("load", saida, 9'b0_1010_1100);

    cyc(1'b0, 1'b0, 1'b0, 1'b1, 9'b1_1111_1111);
    chk("shift1", saida, 9'b0_0101_0110);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 9'b1_1111_1111);
    chk("shift2", saida, 9'b0_0010_1011);

    cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'b0_1010_1100);
    chk("add", saida, 9'b0_1010_1011);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 9'b0_0000_0000);
    chk("add_shift", saida, 9'b0_0101_0101);

    // Priority: load over ad and sh
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 9'b1_1111_0000);
    chk("prio_load", saida, 9'b1_1111_0000);

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'b0_0000_1111);
    chk("load2", saida, 9'b0_0000_1111);
    // ad over sh, no shift
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 9'b1_0101_0000);
    chk("prio_ad", saida, 9'b1_0101_1111);

    // Hold for 5 edges with busy entrada
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 9'(i * 37));
      chk($sformatf("hold%0d", i), saida, 9'b1_0101_1111);
    end

    // Shift WIDTH times, MSB zero-filled, ends at 0
    exp_v = 9'b1_0101_1111;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 9'b1_1111_1111);
      exp_v = {1'b0, exp_v[WIDTH-1:1]};
      chk($sformatf("shw%0d", i), saida, exp_v);
    end
    chk("shw_zero", saida, 9'b0_0000_0000);

    // Reset mid-operation clears immediately
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'b1_1111_1111);
    chk("load_ones", saida, 9'b1_1111_1111);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 9'b1_0101_0101);
    chk("reset_mid", saida, 9'b0_0000_0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 9'b1_0101_0101);
    chk("post_reset_hold", saida, 9'b0_0000_0000);

    // ad into cleared register keeps lower zeros
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'b1_0011_1111);
    chk("ad_from_zero", saida, 9'b1_0011_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_acc
